fft_audio_framer: RTL

//  Transmit side of the FFT sink stream: collects 24-bit audio samples arriving as single-cycle strobes.

---
 rtl/fft_audio_framer.sv | 276 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/fft_audio_framer.sv
// fft_audio_framer: packs strobed 24-bit audio samples into Avalon-ST frames (sop/eop,
// per-frame fftpts/inverse, zero imag) for the FFT sink. Latency: strobe in cycle t -> src_real in t+2.
// Backpressure: src_* held while src_valid & !src_ready; samples buffer in a FIFO, full FIFO drops + sticky overflow.
//
// Ports:
//   clk, reset_n            single rising-edge clock, asynchronous active-low reset
//   en                      frame enable, only looked at when no frame is being written
//   cfg_fftpts, cfg_inverse frame length / direction, captured at the first write of a frame
//   smp_valid, smp_data     one-cycle sample strobe and signed sample
//   ovf_clr, overflow       sticky "sample dropped" flag and its clear
//   src_*                   Avalon-ST source into the FFT sink (ready latency 0)
//
// Build option: define FFT_AUDIO_FRAMER_ERR_EN to report drops inside a frame as src_error=2'b01
// on that frame's eop beat. Without it src_error is tied to 2'b00.
module fft_audio_framer #(
    parameter int DATA_W     = 24,
    parameter int FIFO_DEPTH = 16,
    parameter int PTS_W      = 11,
    parameter int MAX_PTS    = 1024
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              en,
    input  logic [PTS_W-1:0]  cfg_fftpts,
    input  logic              cfg_inverse,
    input  logic              smp_valid,
    input  logic [DATA_W-1:0] smp_data,
    input  logic              ovf_clr,
    output logic              overflow,
    output logic              src_valid,
    input  logic              src_ready,
    output logic              src_sop,
    output logic              src_eop,
    output logic [DATA_W-1:0] src_real,
    output logic [DATA_W-1:0] src_imag,
    output logic [1:0]        src_error,
    output logic [PTS_W-1:0]  src_fftpts,
    output logic              src_inverse
);

    localparam int              AW       = $clog2(FIFO_DEPTH);
    localparam logic [PTS_W-1:0] MIN_N   = PTS_W'(8);
    localparam logic [PTS_W-1:0] MAX_N   = PTS_W'(MAX_PTS);
    localparam logic [PTS_W-1:0] ONE_N   = PTS_W'(1);
    localparam logic [AW:0]      FULL_CNT = (AW+1)'(FIFO_DEPTH);

    // Each FIFO entry carries its frame's length and direction, so the write side can run a
    // frame ahead of the read side without disturbing the frame currently on the output.
    typedef struct packed {
`ifdef FFT_AUDIO_FRAMER_ERR_EN
        logic              err;
`endif
        logic              inv;
        logic [PTS_W-1:0]  n;
        logic [DATA_W-1:0] dat;
    } entry_t;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SEND} state_t;

    // ---------------- storage ----------------
    entry_t            r_mem [FIFO_DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [AW:0]       r_count;

    // ---------------- write side ----------------
    logic [PTS_W-1:0]  r_wr_cnt;
    logic [PTS_W-1:0]  r_wr_n;
    logic              r_wr_inv;
    logic              r_overflow;

    logic              w_cfg_pow2;
    logic [PTS_W-1:0]  w_cfg_n;
    logic              w_wr_first;
    logic [PTS_W-1:0]  w_wr_n;
    logic              w_wr_inv;
    logic              w_wr_last;
    logic              w_push_req;
    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_drop;
    logic              w_pop;
    entry_t            w_wr_entry;
    entry_t            w_rd_entry;

    assign w_cfg_pow2 = ((cfg_fftpts & (cfg_fftpts - ONE_N)) == '0);
    assign w_cfg_n    = (w_cfg_pow2 && cfg_fftpts >= MIN_N && cfg_fftpts <= MAX_N) ? cfg_fftpts : MAX_N;

    // wr_cnt==0 means no frame is being written: the next accepted sample starts one,
    // and only then do en and the cfg inputs matter.
    assign w_wr_first = (r_wr_cnt == '0);
    assign w_wr_n     = w_wr_first ? w_cfg_n : r_wr_n;
    assign w_wr_inv   = w_wr_first ? cfg_inverse : r_wr_inv;
    assign w_wr_last  = (r_wr_cnt == w_wr_n - ONE_N);

    assign w_push_req = smp_valid & (en | ~w_wr_first);
    assign w_full     = (r_count == FULL_CNT);
    assign w_empty    = (r_count == '0);
    // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
    assign w_push     = w_push_req & (~w_full | w_pop);
    assign w_drop     = w_push_req & w_full & ~w_pop;

`ifdef FFT_AUDIO_FRAMER_ERR_EN
    logic r_frame_err;
`endif

    always_comb begin
        w_wr_entry     = '0;
        w_wr_entry.dat = smp_data;
        w_wr_entry.n   = w_wr_n;
        w_wr_entry.inv = w_wr_inv;
`ifdef FFT_AUDIO_FRAMER_ERR_EN
        // Only the eop entry carries the frame's error; a drop never coincides with a push.
        w_wr_entry.err = w_wr_last & r_frame_err;
`endif
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_wr_entry;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr   <= '0;
            r_wr_cnt   <= '0;
            r_wr_n     <= '0;
            r_wr_inv   <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
                r_wr_cnt <= w_wr_last ? '0 : r_wr_cnt + ONE_N;
                if (w_wr_first) begin
                    r_wr_n   <= w_cfg_n;
                    r_wr_inv <= cfg_inverse;
                end
            end
            // A new drop takes priority over a coincident clear.
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (ovf_clr) begin
                r_overflow <= 1'b0;
            end
        end
    end

`ifdef FFT_AUDIO_FRAMER_ERR_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_frame_err <= 1'b0;
        end else if (w_push && w_wr_last) begin
            r_frame_err <= 1'b0;
        end else if (w_drop && !w_wr_first) begin
            r_frame_err <= 1'b1;
        end
    end
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else begin
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // ---------------- read side ----------------
    state_t            r_state;
    state_t            w_state_nxt;
    logic [PTS_W-1:0]  r_rd_cnt;
    logic [PTS_W-1:0]  w_rd_cnt_nxt;
    logic [PTS_W-1:0]  w_rd_cnt_inc;
    logic              w_xfer;
    logic              r_src_valid;
    logic              r_src_sop;
    logic              r_src_eop;
    logic [DATA_W-1:0] r_src_real;
    logic [PTS_W-1:0]  r_src_fftpts;
    logic              r_src_inverse;

    assign w_rd_entry   = r_mem[r_rd_ptr];
    assign w_xfer       = r_src_valid & src_ready;
    // Wrap on the length of the beat being transferred.
    assign w_rd_cnt_inc = (r_rd_cnt == r_src_fftpts - ONE_N) ? '0 : r_rd_cnt + ONE_N;

    always_comb begin
        w_state_nxt  = r_state;
        w_pop        = 1'b0;
        w_rd_cnt_nxt = r_rd_cnt;
        unique case (r_state)
            S_IDLE: begin
                // Leaving on the pushing strobe itself gives the two-cycle strobe-to-output path.
                if (!w_empty || w_push_req) begin
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                w_pop       = 1'b1;
                w_state_nxt = S_SEND;
            end
            S_SEND: begin
                if (w_xfer) begin
                    w_rd_cnt_nxt = w_rd_cnt_inc;
                    if (!w_empty) begin
                        w_pop = 1'b1;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= S_IDLE;
            r_rd_ptr      <= '0;
            r_rd_cnt      <= '0;
            r_src_valid   <= 1'b0;
            r_src_sop     <= 1'b0;
            r_src_eop     <= 1'b0;
            r_src_real    <= '0;
            r_src_fftpts  <= '0;
            r_src_inverse <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_rd_cnt <= w_rd_cnt_nxt;
            if (w_pop) begin
                // sop/eop use the count after this cycle's transfer, so back-to-back reloads line up.
                r_rd_ptr      <= r_rd_ptr + 1'b1;
                r_src_valid   <= 1'b1;
                r_src_sop     <= (w_rd_cnt_nxt == '0);
                r_src_eop     <= (w_rd_cnt_nxt == w_rd_entry.n - ONE_N);
                r_src_real    <= w_rd_entry.dat;
                r_src_fftpts  <= w_rd_entry.n;
                r_src_inverse <= w_rd_entry.inv;
            end else if (w_xfer) begin
                r_src_valid <= 1'b0;
            end
        end
    end

`ifdef FFT_AUDIO_FRAMER_ERR_EN
    logic [1:0] r_src_error;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_src_error <= 2'b00;
        end else if (w_pop) begin
            r_src_error <= {1'b0, w_rd_entry.err};
        end else if (w_xfer) begin
            r_src_error <= 2'b00;
        end
    end
    assign src_error = r_src_error;
`else
    assign src_error = 2'b00;
`endif

    assign overflow    = r_overflow;
    assign src_valid   = r_src_valid;
    assign src_sop     = r_src_sop;
    assign src_eop     = r_src_eop;
    assign src_real    = r_src_real;
    assign src_imag    = '0;
    assign src_fftpts  = r_src_fftpts;
    assign src_inverse = r_src_inverse;

endmodule
